// File: rtl/mul_acc.sv
// Iterative radix-2 shift-and-add multiply / multiply-accumulate unit.
// Produces the low N bits of a*b (MUL) or a*b + acc (MLA) after N iterations.
module mul_acc #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         mode,
  input  logic         set_flags,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] acc,
  output logic [N-1:0] result,
  output logic [3:0]   flags,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    p_q, p_d;
  logic [N-1:0]    m_q, m_d;
  logic [N-1:0]    q_q, q_d;
  logic [CW-1:0]   count_q, count_d;
  logic            sf_q, sf_d;
  logic [N-1:0]    result_q, result_d;
  logic [3:0]      flags_q, flags_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [N-1:0]    p_sum_s;

  assign result = result_q;
  assign flags  = flags_q;
  assign busy   = busy_q;
  assign done   = done_q;

  // Next-state logic for the control FSM and the shift/add datapath.
  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    m_d      = m_q;
    q_d      = q_q;
    count_d  = count_q;
    sf_d     = sf_q;
    result_d = result_q;
    flags_d  = flags_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    p_sum_s  = p_q + (q_q[0] ? m_q : {N{1'b0}});

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
          busy_d  = 1'b1;
          p_d     = mode ? acc : {N{1'b0}};
          m_d     = a;
          q_d     = b;
          count_d = {CW{1'b0}};
          sf_d    = set_flags;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      CALC: begin
        p_d     = p_sum_s;
        m_d     = {m_q[N-2:0], 1'b0};
        q_d     = {1'b0, q_q[N-1:1]};
        count_d = count_q + CW'(1);
        if (count_q == CW'(N - 1)) begin
          state_d  = IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = p_sum_s;
          // C and V are deliberately preserved; only N and Z reflect the product.
          if (sf_q) begin
            flags_d = {flags_q[3:2], (p_sum_s == {N{1'b0}}), p_sum_s[N-1]};
          end else begin
            flags_d = flags_q;
          end
        end else begin
          state_d = CALC;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous abort on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      p_q      <= {N{1'b0}};
      m_q      <= {N{1'b0}};
      q_q      <= {N{1'b0}};
      count_q  <= {CW{1'b0}};
      sf_q     <= 1'b0;
      result_q <= {N{1'b0}};
      flags_q  <= 4'b0000;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      m_q      <= m_d;
      q_q      <= q_d;
      count_q  <= count_d;
      sf_q     <= sf_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_mul_acc.sv
// Scoreboard testbench for mul_acc (N = 8): stimulus pushes expected results,
// a negedge monitor pops and compares them whenever done is presented.
module tb_mul_acc;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic         set_flags = 1'b0;
  logic [N-1:0] a = 8'h00;
  logic [N-1:0] b = 8'h00;
  logic [N-1:0] acc = 8'h00;
  logic [N-1:0] result;
  logic [3:0]   flags;
  logic         busy;
  logic         done;

  typedef struct {
    logic [7:0] res;
    logic [3:0] flg;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [3:0] model_flags = 4'h0;

  mul_acc #(.N(N)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
    .set_flags(set_flags), .a(a), .b(b), .acc(acc),
    .result(result), .flags(flags), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain arithmetic, truncated to 8 bits.
  function automatic exp_t model(input logic md, input logic sf,
                                 input logic [7:0] ia, input logic [7:0] ib,
                                 input logic [7:0] iacc, input int c);
    exp_t e;
    int unsigned full;
    full = int'(ia) * int'(ib) + (md ? int'(iacc) : 0);
    e.res = full[7:0];
    if (sf) begin
      model_flags[0] = e.res[7];
      model_flags[1] = (e.res == 8'h00);
    end
    e.flg = model_flags;
    e.cyc = c;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", 32'(result), 32'(e.res));
        chk("flags", 32'(flags), 32'(e.flg));
        chk("latency", 32'(cyc), 32'(e.cyc + N));
        chk("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || sb.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      chk("idle_timeout", 32'd1, 32'd0);
      sb.delete();
    end
  endtask

  task automatic issue(input logic md, input logic sf, input logic [7:0] ia,
                       input logic [7:0] ib, input logic [7:0] iacc);
    wait_idle();
    @(negedge clk);
    start = 1'b1; mode = md; set_flags = sf; a = ia; b = ib; acc = iacc;
    @(posedge clk); #1;
    sb.push_back(model(md, sf, ia, ib, iacc, cyc));
    @(negedge clk);
    chk("busy_after_start", 32'(busy), 32'd1);
    start = 1'b0;
    mode = 1'($urandom); set_flags = 1'($urandom);
    a = 8'($urandom); b = 8'($urandom); acc = 8'($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e2;
    repeat (3) @(negedge clk);
    chk("rst_result", 32'(result), 32'h0);
    chk("rst_flags", 32'(flags), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    reset_n = 1'b1;

    // Directed operations from the datasheet examples.
    issue(1'b0, 1'b1, 8'h07, 8'h06, 8'h00);
    issue(1'b0, 1'b1, 8'h0F, 8'h09, 8'h00);
    issue(1'b0, 1'b0, 8'hFF, 8'hFF, 8'h00);
    issue(1'b0, 1'b1, 8'h80, 8'h02, 8'h00);

    wait_idle();
    @(negedge clk);
    force dut.flags_q = 4'hC;
    #1;
    release dut.flags_q;
    model_flags = 4'hC;
    @(negedge clk);
    chk("flags_preload", 32'(flags), 32'hC);
    issue(1'b1, 1'b1, 8'h10, 8'h10, 8'h05);

    // start while busy with other operands must be ignored.
    issue(1'b0, 1'b1, 8'h0B, 8'h0D, 8'h00);
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; a = 8'($urandom); b = 8'($urandom); mode = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;

    // start held high through done: next op accepted on the edge after done.
    wait_idle();
    @(negedge clk);
    start = 1'b1; mode = 1'b0; set_flags = 1'b1; a = 8'h21; b = 8'h03; acc = 8'h00;
    @(posedge clk); #1;
    sb.push_back(model(1'b0, 1'b1, 8'h21, 8'h03, 8'h00, cyc));
    @(negedge clk);
    mode = 1'b1; set_flags = 1'b0; a = 8'h05; b = 8'h05; acc = 8'h07;
    repeat (N) @(negedge clk);
    chk("b2b_done", 32'(done), 32'd1);
    @(posedge clk); #1;
    e2 = model(1'b1, 1'b0, 8'h05, 8'h05, 8'h07, cyc);
    sb.push_back(e2);
    @(negedge clk);
    chk("b2b_busy_rise", 32'(busy), 32'd1);
    chk("b2b_done_fall", 32'(done), 32'd0);
    start = 1'b0;

    // Asynchronous reset three cycles into an operation.
    wait_idle();
    @(negedge clk);
    start = 1'b1; mode = 1'b0; set_flags = 1'b1; a = 8'h33; b = 8'h44;
    @(posedge clk); #1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    model_flags = 4'h0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_result", 32'(result), 32'h0);
    chk("midrst_flags", 32'(flags), 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("midrst_no_done_busy", 32'(busy), 32'd0);
    issue(1'b0, 1'b0, 8'h03, 8'h05, 8'h00);

    // Randomized operations against the reference model.
    for (int i = 0; i < 25; i++) begin
      issue(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    end
    for (int i = 0; i < 4; i++) begin
      issue(1'($urandom), 1'b1, 8'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 8'h00);
    end
    wait_idle();
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
